// File: rtl/i2c_slave_if.sv
`default_nettype none
// ============================================================================
// i2c_slave_if
// Bus clock and register-file write/status signals of the I2C responder.
// Revision: 1.0
// ============================================================================
interface i2c_slave_if;
    logic       scl;
    logic       busy;
    logic       addr_hit;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output scl,
        input  busy, addr_hit, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  scl,
        output busy, addr_hit, wr_valid, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// i2c_slave
// Oversampling I2C responder with a 16x8 register file and auto-increment ptr.
// Revision: 1.0
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    inout  wire        sda,
    i2c_slave_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_ADDR   = 3'd1,
        ST_ACK_ADDR  = 3'd2,
        ST_RX_BYTE   = 3'd3,
        ST_ACK_BYTE  = 3'd4,
        ST_TX_BYTE   = 3'd5,
        ST_RX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    state_t     state_q;
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       first_byte_q;
    logic       rw_q;
    logic [3:0] ptr_q;
    logic [7:0] mem_q [16];
    logic       sda_low_q;
    logic       busy_q;
    logic       addr_hit_q;
    logic       wr_valid_q;
    logic [3:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_sync_q[1] & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q[1] & scl_hist_q;
    assign start_det = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];
    assign rx_byte   = {shift_q[6:0], sda_sync_q[1]};

    // Open drain: only ever pull low
    assign sda          = sda_low_q ? 1'b0 : 1'bz;
    assign bus.busy     = busy_q;
    assign bus.addr_hit = addr_hit_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            scl_sync_q   <= 2'b11;
            sda_sync_q   <= 2'b11;
            scl_hist_q   <= 1'b1;
            sda_hist_q   <= 1'b1;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            first_byte_q <= 1'b0;
            rw_q         <= 1'b0;
            ptr_q        <= 4'd0;
            for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
            sda_low_q    <= 1'b0;
            busy_q       <= 1'b0;
            addr_hit_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'h00;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
            addr_hit_q <= 1'b0;
            wr_valid_q <= 1'b0;

            if (stop_det) begin
                state_q   <= ST_IDLE;
                sda_low_q <= 1'b0;
                busy_q    <= 1'b0;
            end else if (start_det) begin
                state_q      <= ST_RX_ADDR;
                bit_cnt_q    <= 4'd0;
                first_byte_q <= 1'b1;
                sda_low_q    <= 1'b0;
                busy_q       <= 1'b1;
            end else begin
                case (state_q)
                    ST_RX_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    state_q    <= ST_ACK_ADDR;
                                    addr_hit_q <= 1'b1;
                                    rw_q       <= rx_byte[0];
                                end else begin
                                    state_q <= ST_WAIT_STOP;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    // First falling edge opens the ACK slot, the second closes it
                    ST_ACK_ADDR, ST_ACK_BYTE: begin
                        if (scl_fall) begin
                            if (!sda_low_q) begin
                                sda_low_q <= 1'b1;
                            end else if (state_q == ST_ACK_ADDR && rw_q) begin
                                shift_q   <= mem_q[ptr_q];
                                sda_low_q <= ~mem_q[ptr_q][7];
                                ptr_q     <= ptr_q + 4'd1;
                                bit_cnt_q <= 4'd0;
                                state_q   <= ST_TX_BYTE;
                            end else begin
                                sda_low_q <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= ST_RX_BYTE;
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                state_q   <= ST_ACK_BYTE;
                                if (first_byte_q) begin
                                    ptr_q        <= rx_byte[3:0];
                                    first_byte_q <= 1'b0;
                                end else begin
                                    mem_q[ptr_q] <= rx_byte;
                                    wr_valid_q   <= 1'b1;
                                    wr_addr_q    <= ptr_q;
                                    wr_data_q    <= rx_byte;
                                    ptr_q        <= ptr_q + 4'd1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd7) begin
                                sda_low_q <= 1'b0;
                                state_q   <= ST_RX_ACK;
                            end else begin
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_low_q <= ~shift_q[6];
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    // bit_cnt_q == 8 marks a received master ACK awaiting the slot's end
                    ST_RX_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync_q[1]) state_q <= ST_WAIT_STOP;
                            else               bit_cnt_q <= 4'd8;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            shift_q   <= mem_q[ptr_q];
                            sda_low_q <= ~mem_q[ptr_q][7];
                            ptr_q     <= ptr_q + 4'd1;
                            bit_cnt_q <= 4'd0;
                            state_q   <= ST_TX_BYTE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// tb_i2c_slave
// Bit-banged I2C master with a register-file model checking the responder.
// Revision: 1.0
// ============================================================================
module tb_i2c_slave;
    localparam logic [6:0] SLAVE_ADDR = 7'b1111000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    i2c_slave_if bus ();

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .sda (sda),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [16];
    logic [3:0]  ref_ptr;
    logic [11:0] exp_wr [$];
    logic [11:0] wr_log [$];
    int          exp_wr_total = 0;
    int          exp_hits     = 0;
    int          wr_hi_cnt    = 0;
    int          hit_cnt      = 0;
    logic [7:0]  tx_buf [8];

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wr_hi_cnt++;
            wr_log.push_back({bus.wr_addr, bus.wr_data});
        end
        if (bus.addr_hit) hit_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every bit task starts just after SCL fell and ends with SCL falling again
    task automatic bit_out(input logic b);
        tick(4); m_sda_low = ~b;
        tick(4); bus.scl = 1'b1;
        tick(8); bus.scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        tick(4); m_sda_low = 1'b0;
        tick(4); bus.scl = 1'b1;
        tick(4); b = sda;
        tick(4); bus.scl = 1'b0;
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b0;
        tick(4); bus.scl = 1'b1;
        tick(8); m_sda_low = 1'b1;
        tick(8); bus.scl = 1'b0;
    endtask

    task automatic i2c_stop;
        tick(4); m_sda_low = 1'b1;
        tick(4); bus.scl = 1'b1;
        tick(8); m_sda_low = 1'b0;
        tick(8);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
    endtask

    task automatic check_writes;
        check("wr_count", wr_log.size(), exp_wr.size());
        while (wr_log.size() > 0 && exp_wr.size() > 0)
            check("wr_addr_data", wr_log.pop_front(), exp_wr.pop_front());
        wr_log.delete();
        exp_wr.delete();
        check("wr_pulse_cycles", wr_hi_cnt, exp_wr_total);
    endtask

    // Writes tx_buf[0..n-1]; byte 0 is the pointer
    task automatic write_txn(input logic [6:0] a, input int n);
        logic        ack;
        logic        hit;
        logic [11:0] last;
        bit          wrote;
        hit   = (a == SLAVE_ADDR);
        wrote = 1'b0;
        last  = '0;
        i2c_start;
        check("busy_after_start", bus.busy, 1);
        send_byte({a, 1'b0}, ack);
        check("addr_ack", ack, hit ? 0 : 1);
        if (hit) exp_hits++;
        for (int i = 0; i < n; i++) begin
            send_byte(tx_buf[i], ack);
            check("data_ack", ack, hit ? 0 : 1);
            if (hit) begin
                if (i == 0) begin
                    ref_ptr = tx_buf[0][3:0];
                end else begin
                    last = {ref_ptr, tx_buf[i]};
                    exp_wr.push_back(last);
                    exp_wr_total++;
                    ref_mem[ref_ptr] = tx_buf[i];
                    ref_ptr = ref_ptr + 4'd1;
                    wrote = 1'b1;
                end
            end
        end
        i2c_stop;
        check("busy_after_stop", bus.busy, 0);
        if (wrote) check("wr_hold", {bus.wr_addr, bus.wr_data}, last);
    endtask

    task automatic read_txn(input logic [7:0] p, input int n, input bit set_ptr);
        logic       ack;
        logic [7:0] d;
        i2c_start;
        if (set_ptr) begin
            send_byte({SLAVE_ADDR, 1'b0}, ack);
            check("rd_setup_addr_ack", ack, 0);
            send_byte(p, ack);
            check("rd_setup_ptr_ack", ack, 0);
            exp_hits++;
            ref_ptr = p[3:0];
            i2c_start;
        end
        send_byte({SLAVE_ADDR, 1'b1}, ack);
        check("rd_addr_ack", ack, 0);
        exp_hits++;
        for (int i = 0; i < n; i++) begin
            recv_byte(d, (i == n - 1));
            check("rd_data", d, ref_mem[ref_ptr]);
            ref_ptr = ref_ptr + 4'd1;
        end
        i2c_stop;
        check("rd_busy_after_stop", bus.busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic       ack;
        logic [6:0] bad_addr;
        logic [7:0] p;
        int         n;

        bus.scl   = 1'b1;
        m_sda_low = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 4'd0;
        tick(5);
        check("rst_busy", bus.busy, 0);
        check("rst_addr_hit", bus.addr_hit, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_sda", sda, 1);
        rst = 1'b0;
        tick(10);

        // Basic write and read-back through a repeated START
        tx_buf[0] = 8'h03; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h5A;
        write_txn(SLAVE_ADDR, 3);
        check_writes();
        read_txn(8'h03, 3, 1);

        // Foreign address must be ignored completely
        tx_buf[0] = 8'hFF;
        write_txn(7'b1010101, 1);
        check_writes();

        // Pointer wrap 15 -> 0
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        write_txn(SLAVE_ADDR, 3);
        check_writes();
        read_txn(8'h0F, 2, 1);

        // Reset while the slave is driving a 0 data bit (mem[0] = 22)
        i2c_start;
        send_byte({SLAVE_ADDR, 1'b0}, ack);
        send_byte(8'h00, ack);
        i2c_start;
        send_byte({SLAVE_ADDR, 1'b1}, ack);
        check("tx_addr_ack", ack, 0);
        exp_hits += 2;
        tick(6);
        check("tx_bit7_low", sda, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_sda_release", sda, 1);
        check("rst_mid_busy", bus.busy, 0);
        tick(2);
        bus.scl = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(10);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_ptr = 4'd0;
        wr_log.delete();

        tx_buf[0] = 8'h06; tx_buf[1] = 8'h3C; tx_buf[2] = 8'hC3;
        tx_buf[3] = 8'h96; tx_buf[4] = 8'h69;
        write_txn(SLAVE_ADDR, 5);
        check_writes();
        read_txn(8'h04, 4, 1);

        // STOP after 4 data bits: no write, pointer keeps the loaded value
        i2c_start;
        send_byte({SLAVE_ADDR, 1'b0}, ack);
        check("mid_addr_ack", ack, 0);
        send_byte(8'h07, ack);
        check("mid_ptr_ack", ack, 0);
        exp_hits++;
        ref_ptr = 4'd7;
        for (int i = 0; i < 4; i++) bit_out(1'($urandom));
        i2c_stop;
        check("mid_busy", bus.busy, 0);
        check_writes();
        read_txn(8'h00, 2, 0);

        // Randomized write / read-back sequences
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 4);
            p = 8'($urandom);
            tx_buf[0] = p;
            for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
            write_txn(SLAVE_ADDR, n + 1);
            check_writes();
            read_txn(p, n + 1, 1);
            if (k % 2 == 1) begin
                bad_addr = 7'($urandom);
                if (bad_addr == SLAVE_ADDR) bad_addr = bad_addr ^ 7'h01;
                tx_buf[0] = 8'($urandom);
                tx_buf[1] = 8'($urandom);
                write_txn(bad_addr, 2);
                check_writes();
            end
        end

        check("addr_hit_total", hit_cnt, exp_hits);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
